// File: rtl/led_rgb_scheduler.sv
// ---------------------------------------------------------------------------
// led_rgb_scheduler
//
// This block shares one board RGB LED between NUM_REQ status requesters, for
// example a PS heartbeat, link-up or error source. The LED itself is driven by
// the led_rgb blinker.
//
// Arbitration uses fixed priority, and index 0 is the highest. Once a
// requester owns the LED, it keeps it for at least MIN_SLOT cycles before a
// higher-priority request can take it. If the owner drops its request, the
// LED is released at once.
//
// Before the LED goes to the next owner, the blinker's status feedback is
// used to let any running pattern finish (drain).
//
// Ports:
//   clk                   clock
//   reset                 synchronous, active-high reset
//   req[NUM_REQ]          level request, bit i = requester i
//   req_color[3*NUM_REQ]  per requester {b,g,r} enable mask, slice [3i+2:3i]
//   req_blink[NUM_REQ]    per requester: 1 = blink, 0 = constant on
//   req_duration[32*N]    per requester blink half-period, slice [32i+31:32i]
//   led_sts[3]            {B,G,R} pattern-running status from the blinker
//   enable_/mode_/holded_/duration_{r,g,b}
//                         blinker controls (all registered)
//   grant[NUM_REQ]        one-hot current owner, 0 when none
//   busy                  scheduler is not idle
//   drain_timeout         one-cycle pulse when a drain gives up waiting
// ---------------------------------------------------------------------------
module led_rgb_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MIN_SLOT      = 1000,
  parameter int unsigned DRAIN_TIMEOUT = 200000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [3*NUM_REQ-1:0]    req_color,
  input  logic [NUM_REQ-1:0]      req_blink,
  input  logic [32*NUM_REQ-1:0]   req_duration,
  input  logic [2:0]              led_sts,
  output logic                    enable_r,
  output logic                    enable_g,
  output logic                    enable_b,
  output logic                    mode_r,
  output logic                    mode_g,
  output logic                    mode_b,
  output logic                    holded_r,
  output logic                    holded_g,
  output logic                    holded_b,
  output logic [31:0]             duration_r,
  output logic [31:0]             duration_g,
  output logic [31:0]             duration_b,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    drain_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          slot_cnt_q, slot_cnt_d;
  logic [31:0]          drain_cnt_q, drain_cnt_d;
  logic [2:0]           enable_q, enable_d;   // {b,g,r}
  logic [2:0]           holded_q, holded_d;   // {b,g,r}
  // All three channels always receive the same mode and duration, so one
  // register drives each of them.
  logic                 mode_q, mode_d;
  logic [31:0]          dur_q, dur_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  // Per-requester views of the packed configuration buses.
  logic [2:0]  color_arr [NUM_REQ];
  logic [31:0] dur_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign color_arr[gi] = req_color[3*gi +: 3];
    assign dur_arr[gi]   = req_duration[32*gi +: 32];
  end

  // Fixed-priority winner: scanning from the top down leaves the lowest
  // set index in place.
  logic [NUM_REQ-1:0] win_onehot;
  logic [2:0]         win_color;
  logic               win_blink;
  logic [31:0]        win_dur;

  always_comb begin
    win_onehot = '0;
    win_color  = '0;
    win_blink  = 1'b0;
    win_dur    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_color     = color_arr[i];
        win_blink     = req_blink[i];
        win_dur       = dur_arr[i];
      end
    end
  end

  // The owner is identified by grant_q.
  // Subtracting 1 from a one-hot value yields a mask of every lower
  // (i.e. higher-priority) index.
  logic [NUM_REQ-1:0] higher_mask;
  logic               owner_req;
  logic               higher_req;
  logic               win_blink_eff;

  assign higher_mask   = grant_q - NUM_REQ'(1);
  assign owner_req     = |(req & grant_q);
  assign higher_req    = |(req & higher_mask);
  // A zero half-period cannot be shown as constant-on, so it is forced to
  // blink mode.
  assign win_blink_eff = win_blink | (win_dur == 32'd0);

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    enable_d    = enable_q;
    holded_d    = holded_q;
    mode_d      = mode_q;
    dur_d       = dur_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        enable_d    = '0;
        holded_d    = '0;
        grant_d     = '0;
        mode_d      = 1'b0;
        dur_d       = '0;
        slot_cnt_d  = '0;
        drain_cnt_d = '0;
        // Wait for a dark LED, in case the blinker was not reset together
        // with this block.
        if (|req && (led_sts == 3'b000)) begin
          state_d  = S_ACTIVE;
          enable_d = win_color;
          mode_d   = win_blink_eff;
          holded_d = {3{win_blink_eff}} & win_color;
          dur_d    = win_dur;
          grant_d  = win_onehot;
        end
      end

      S_ACTIVE: begin
        if (slot_cnt_q < MIN_SLOT) begin
          slot_cnt_d = slot_cnt_q + 32'd1;
        end
        // An owner drop releases immediately. Higher-priority requesters
        // must wait out the minimum slot.
        if (!owner_req || (higher_req && (slot_cnt_q >= MIN_SLOT))) begin
          state_d     = S_DRAIN;
          enable_d    = '0;
          holded_d    = '0;
          grant_d     = '0;
          drain_cnt_d = '0;
          // mode/duration are kept so the current half-period can finish.
        end
      end

      S_DRAIN: begin
        // For the first two cycles, status may still reflect the blinker's
        // previous state, so it is not trusted.
        if ((drain_cnt_q >= 32'd2) && (led_sts == 3'b000)) begin
          state_d = S_IDLE;
          mode_d  = 1'b0;
          dur_d   = '0;
        end else if (drain_cnt_q >= DRAIN_TIMEOUT) begin
          state_d   = S_IDLE;
          mode_d    = 1'b0;
          dur_d     = '0;
          timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slot_cnt_q  <= '0;
      drain_cnt_q <= '0;
      enable_q    <= '0;
      holded_q    <= '0;
      mode_q      <= 1'b0;
      dur_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      enable_q    <= enable_d;
      holded_q    <= holded_d;
      mode_q      <= mode_d;
      dur_q       <= dur_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign enable_r      = enable_q[0];
  assign enable_g      = enable_q[1];
  assign enable_b      = enable_q[2];
  assign holded_r      = holded_q[0];
  assign holded_g      = holded_q[1];
  assign holded_b      = holded_q[2];
  assign mode_r        = mode_q;
  assign mode_g        = mode_q;
  assign mode_b        = mode_q;
  assign duration_r    = dur_q;
  assign duration_g    = dur_q;
  assign duration_b    = dur_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_led_rgb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_rgb_scheduler
//
// This is a directed testbench for led_rgb_scheduler, built with NUM_REQ=4,
// MIN_SLOT=10 and DRAIN_TIMEOUT=20.
//
// The bench plays the blinker by driving led_sts by hand. Expected values
// are worked out from the state timing:
//   - a grant appears one edge after the request;
//   - DRAIN lasts at least three cycles;
//   - IDLE takes one cycle before the next grant.
// ---------------------------------------------------------------------------
module tb_led_rgb_scheduler;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [3*NR-1:0]  req_color;
  logic [NR-1:0]    req_blink;
  logic [32*NR-1:0] req_duration;
  logic [2:0]    led_sts;
  logic enable_r, enable_g, enable_b;
  logic mode_r, mode_g, mode_b;
  logic holded_r, holded_g, holded_b;
  logic [31:0] duration_r, duration_g, duration_b;
  logic [NR-1:0] grant;
  logic busy, drain_timeout;

  int n_checks = 0;
  int n_errors = 0;

  led_rgb_scheduler #(
    .NUM_REQ(NR),
    .MIN_SLOT(10),
    .DRAIN_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_color(req_color),
    .req_blink(req_blink),
    .req_duration(req_duration),
    .led_sts(led_sts),
    .enable_r(enable_r),
    .enable_g(enable_g),
    .enable_b(enable_b),
    .mode_r(mode_r),
    .mode_g(mode_g),
    .mode_b(mode_b),
    .holded_r(holded_r),
    .holded_g(holded_g),
    .holded_b(holded_b),
    .duration_r(duration_r),
    .duration_g(duration_g),
    .duration_b(duration_b),
    .grant(grant),
    .busy(busy),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  wire [2:0] en_bgr   = {enable_b, enable_g, enable_r};
  wire [2:0] mode_bgr = {mode_b, mode_g, mode_r};
  wire [2:0] hold_bgr = {holded_b, holded_g, holded_r};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock edge, then move 1 time unit past it so that inputs
  // can be driven and outputs sampled.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int idx, input logic [2:0] color,
                         input logic blink, input logic [31:0] dur);
    req_color[3*idx +: 3]     = color;
    req_blink[idx]            = blink;
    req_duration[32*idx +: 32] = dur;
  endtask

  initial begin
    reset        = 1'b1;
    req          = '0;
    req_color    = '0;
    req_blink    = '0;
    req_duration = '0;
    led_sts      = 3'b000;
    tick(2);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_en", 64'(en_bgr), 64'h0);
    check("rst_mode", 64'(mode_bgr), 64'h0);
    check("rst_hold", 64'(hold_bgr), 64'h0);
    check("rst_dur", 64'({duration_r, duration_g}), 64'h0);
    check("rst_dto", 64'(drain_timeout), 64'h0);
    reset = 1'b0;

    // Constant red on requester 2, then drop it.
    set_cfg(2, 3'b001, 1'b0, 32'd7);
    req = 4'b0100;
    tick(1);
    check("t1_grant", 64'(grant), 64'h4);
    check("t1_en", 64'(en_bgr), 64'h1);
    check("t1_mode", 64'(mode_bgr), 64'h0);
    check("t1_hold", 64'(hold_bgr), 64'h0);
    check("t1_dur_r", 64'(duration_r), 64'd7);
    check("t1_busy", 64'(busy), 64'h1);
    led_sts = 3'b001;
    req = 4'b0000;
    tick(1);
    check("t1_drop_grant", 64'(grant), 64'h0);
    check("t1_drop_en", 64'(en_bgr), 64'h0);
    check("t1_drain_dur", 64'(duration_r), 64'd7);
    led_sts = 3'b000;
    tick(2);
    check("t1_drain_busy", 64'(busy), 64'h1);
    tick(1);
    check("t1_idle_busy", 64'(busy), 64'h0);
    check("t1_idle_dur", 64'(duration_r), 64'h0);

    // Requester 1 is blinking white. Requester 0 arrives at slot_cnt=3 and
    // must wait until slot_cnt reaches 10.
    set_cfg(1, 3'b111, 1'b1, 32'd5);
    set_cfg(0, 3'b010, 1'b1, 32'd3);
    req = 4'b0010;
    tick(1);
    check("t2_grant1", 64'(grant), 64'h2);
    check("t2_hold", 64'(hold_bgr), 64'h7);
    check("t2_mode", 64'(mode_bgr), 64'h7);
    check("t2_dur_g", 64'(duration_g), 64'd5);
    led_sts = 3'b111;
    tick(3);
    req = 4'b0011;
    tick(6);
    check("t2_hold_slot9", 64'(grant), 64'h2);
    tick(1);
    check("t2_hold_slot10", 64'(grant), 64'h2);
    tick(1);
    check("t2_preempt_grant", 64'(grant), 64'h0);
    check("t2_preempt_hold", 64'(hold_bgr), 64'h0);
    check("t2_preempt_en", 64'(en_bgr), 64'h0);
    check("t2_keep_mode", 64'(mode_bgr), 64'h7);
    check("t2_keep_dur", 64'(duration_b), 64'd5);
    tick(4);
    check("t2_wait_sts_busy", 64'(busy), 64'h1);
    check("t2_wait_sts_grant", 64'(grant), 64'h0);
    led_sts = 3'b000;
    tick(1);
    check("t2_idle_busy", 64'(busy), 64'h0);
    check("t2_idle_grant", 64'(grant), 64'h0);
    tick(1);
    check("t2_grant0", 64'(grant), 64'h1);
    check("t2_grant0_en", 64'(en_bgr), 64'h2);
    check("t2_grant0_hold", 64'(hold_bgr), 64'h2);
    check("t2_grant0_dur", 64'(duration_g), 64'd3);
    req = 4'b0000;
    tick(4);
    check("t2_end_busy", 64'(busy), 64'h0);

    // Lower-priority requester 3 never preempts requester 1. Requester 3
    // then gets dur=0 with blink=0, which must be forced into blink mode.
    set_cfg(3, 3'b100, 1'b0, 32'd0);
    req = 4'b1010;
    tick(1);
    check("t3_grant1", 64'(grant), 64'h2);
    for (int i = 0; i < 3; i++) begin
      tick(10);
      check("t3_no_preempt", 64'(grant), 64'h2);
    end
    req = 4'b1000;
    tick(1);
    check("t3_drop_grant", 64'(grant), 64'h0);
    check("t3_drop_busy", 64'(busy), 64'h1);
    tick(3);
    check("t3_idle_busy", 64'(busy), 64'h0);
    check("t3_idle_grant", 64'(grant), 64'h0);
    tick(1);
    check("t4_grant3", 64'(grant), 64'h8);
    check("t4_en", 64'(en_bgr), 64'h4);
    check("t4_mode_forced", 64'(mode_bgr), 64'h7);
    check("t4_hold", 64'(hold_bgr), 64'h4);
    check("t4_dur_zero", 64'(duration_b), 64'h0);
    req = 4'b0000;
    tick(4);
    check("t4_end_busy", 64'(busy), 64'h0);

    // Drain timeout: the status stays lit throughout the drain.
    set_cfg(2, 3'b001, 1'b0, 32'd9);
    req = 4'b0100;
    tick(1);
    check("t5_grant2", 64'(grant), 64'h4);
    led_sts = 3'b001;
    req = 4'b0000;
    tick(1);
    check("t5_drain_dur", 64'(duration_r), 64'd9);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t5_no_pulse", 64'({busy, drain_timeout, grant}), 64'({1'b1, 1'b0, 4'b0000}));
    end
    tick(1);
    check("t5_pulse", 64'(drain_timeout), 64'h1);
    check("t5_pulse_busy", 64'(busy), 64'h0);
    check("t5_pulse_dur", 64'(duration_r), 64'h0);
    tick(1);
    check("t5_pulse_end", 64'(drain_timeout), 64'h0);
    check("t5_blocked", 64'(grant), 64'h0);
    tick(2);
    check("t5_still_blocked", 64'(grant), 64'h0);
    led_sts = 3'b000;
    tick(1);
    check("t5_grant0", 64'(grant), 64'h1);

    // Reset in the middle of ACTIVE.
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t6_rst_grant", 64'(grant), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_en", 64'({en_bgr, mode_bgr, hold_bgr}), 64'h0);
    check("t6_rst_dur", 64'(duration_g), 64'h0);
    reset = 1'b0;
    tick(1);
    check("t6_regrant", 64'(grant), 64'h1);
    check("t6_regrant_busy", 64'(busy), 64'h1);
    check("t6_regrant_en", 64'(en_bgr), 64'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_rgb_scheduler.md
Name: led_rgb_scheduler

Overview:
- Shares one board RGB LED (driven by the led_rgb blinker) between NUM_REQ status requesters, e.g. PS heartbeat, link-up and error sources.
- Arbitrates by fixed priority, with index 0 highest, and enforces a minimum display slot against flicker.
- Drives the blinker's enable/mode/holded/duration inputs.
- Uses the blinker's LED_x_STS feedback to drain a running pattern before handing the LED to the next requester.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
MIN_SLOT, 1000, cycles a grant is held before a higher-priority request may preempt it
DRAIN_TIMEOUT, 200000000, max cycles to wait for blinker status to clear

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request, bit i = requester i
req_color  in  3*NUM_REQ  per requester {b,g,r} enable mask, slice [3i+2:3i]
req_blink  in  NUM_REQ  per requester: 1 = blink, 0 = constant on
req_duration  in  32*NUM_REQ  per requester blink half-period in cycles, slice [32i+31:32i]
led_sts  in  3  {LED_B_STS,LED_G_STS,LED_R_STS} from the blinker
enable_r/g/b  out  1 each  to blinker
mode_r/g/b  out  1 each  to blinker
holded_r/g/b  out  1 each  to blinker
duration_r/g/b  out  32 each  to blinker
grant  out  NUM_REQ  one-hot current owner, 0 when none
busy  out  1  state != IDLE
drain_timeout  out  1  single-cycle pulse on a drain timeout

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. On reset the state returns to IDLE and the slot and drain counters clear, including mid-pattern.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - Outputs enable/holded/grant are 0.
  - Grant occurs only when |req && led_sts==0. This guards against a blinker that was not reset together with the scheduler.
  - Winner w is the lowest set index of req. Its color, blink and duration are latched, and the state moves to ACTIVE.
  - On the same edge: enable_x=color[x], mode_x=blink', holded_x=blink'&color[x], duration_x=dur for all three channels, grant=onehot(w).
  - blink' = blink | (dur==0). A zero duration is forced to blink mode.
- ACTIVE:
  - slot_cnt increments each cycle, saturating at MIN_SLOT.
  - Latched configuration is frozen. Changes on w's req_* inputs are ignored until the next grant.
  - Exit to DRAIN when req[w]==0, effective immediately regardless of slot_cnt.
  - Exit to DRAIN when any req[j] with j<w is set and slot_cnt>=MIN_SLOT.
  - Requests with j>w never preempt.
  - On exit edge: enable_x=0, holded_x=0, grant=0. mode_x and duration_x keep their values so a blinking pattern finishes its current half-period.
- DRAIN:
  - drain_cnt counts from 0.
  - led_sts is ignored while drain_cnt<2, which covers the blinker's one-cycle state update.
  - From drain_cnt>=2: if led_sts==0, go to IDLE and clear mode_x/duration_x.
  - If drain_cnt reaches DRAIN_TIMEOUT first: pulse drain_timeout for 1 cycle, go to IDLE and clear mode_x/duration_x. IDLE will then wait for led_sts==0 before granting.
- Re-arbitration after DRAIN happens in IDLE, so a grant costs at least 1 idle cycle.
- Simultaneous events:
  - A drop of req[w] together with a higher-priority request takes the drop path. The result is the same DRAIN, and the new winner is picked in IDLE.
  - A request rising during DRAIN is only seen in IDLE.
- color==000 is granted normally. Nothing lights and led_sts stays 0, so DRAIN takes exactly 3 cycles.
- Widths:
  - Counters are 32-bit. slot_cnt saturates, and drain_cnt stops at DRAIN_TIMEOUT.
  - grant is always one-hot or zero.

Test Plan:
- NUM_REQ=4, MIN_SLOT=10. req=0100, color2=001, blink2=0. Expected: the cycle after the req edge has grant=0100, enable_r=1, mode_r=0, enable_g=enable_b=0. Dropping req2 gives grant=0 and enable_r=0 on the next edge.
- With req1 granted (blink=1, dur=5, color=111), assert req0 at slot_cnt=3. Expected: no preemption until slot_cnt=10, then DRAIN with holded=0. Grant goes to 0001 only after the model blinker reports led_sts=000.
- Assert req3 while req1 is held. Expected: grant stays 0010 indefinitely, and req3 is granted only after req1 drops and drain completes.
- Set dur=0 and blink=0. Expected: mode_x=1 and duration_x=0 at grant.
- Drain timeout: DRAIN_TIMEOUT=20, tie led_sts=001 during drain. Expected: drain_timeout pulses for exactly 1 cycle at drain_cnt=20, and no new grant occurs until led_sts returns to 000.
- Assert reset mid-ACTIVE for 1 cycle. Expected: all outputs 0 on the next edge and busy=0. The same pending req is re-granted 1 cycle after reset deasserts, provided led_sts==0.
